// File: rtl/imem_dmem_arbiter_pkg.sv
// rtl/imem_dmem_arbiter_pkg.sv - shared state and grant encodings for the I/D memory arbiter
package imem_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// rtl/imem_dmem_arbiter_if.sv - CPU-port and memory-port signal bundle for the arbiter
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              i_read;
  logic [31:0]       i_address;
  logic [31:0]       i_readdata;
  logic              i_busywait;
  logic              d_read;
  logic              d_write;
  logic [31:0]       d_address;
  logic [31:0]       d_writedata;
  logic [31:0]       d_readdata;
  logic              d_busywait;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_busywait;
  logic              timeout_err;

  // The arbiter itself.
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata, timeout_err
  );

  // The surrounding pipeline stages and memory.
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata, timeout_err
  );

endinterface

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - busy-cycle counter that aborts stuck memory accesses and flags a sticky error
module arb_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired,
  output logic o_timeout_err
);

  logic [TO_W-1:0] r_cnt;
  logic            r_err;

  // Expiry fires on the edge that would bring the count to TIMEOUT.
  assign o_expired     = i_count && (r_cnt == TO_W'(TIMEOUT - 1));
  assign o_timeout_err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_count) begin
        r_cnt <= r_cnt + TO_W'(1);
      end
      if (o_expired) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - alternating-priority arbiter sharing one word memory between fetch and data ports
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input logic                  CLK,
  input logic                  RESET,
  imem_dmem_arbiter_if.slave   bus
);

  state_t              r_state;
  logic                r_last_grant;
  logic                r_i_done;
  logic                r_d_done;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [31:0]         r_mem_writedata;
  logic [31:0]         r_i_readdata;
  logic [31:0]         r_d_readdata;

  logic w_i_elig;
  logic w_d_elig;
  logic w_grant_i;
  logic w_grant_any;
  logic w_count;
  logic w_expired;
  logic w_timeout_err;
  logic w_unused_addr_bits;

  // A requester whose done pulse is still high is finishing, not asking again.
  assign w_i_elig    = bus.i_read & ~r_i_done;
  assign w_d_elig    = (bus.d_read | bus.d_write) & ~r_d_done;
  assign w_grant_i   = w_i_elig && (!w_d_elig || r_last_grant == GRANT_DATA);
  assign w_grant_any = (r_state == IDLE) && (w_i_elig || w_d_elig);
  assign w_count     = (r_state != IDLE) && bus.mem_busywait;

  assign w_unused_addr_bits = ^{bus.i_address[31:ADDR_W+2], bus.i_address[1:0],
                                bus.d_address[31:ADDR_W+2], bus.d_address[1:0]};

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk           (CLK),
    .rst           (RESET),
    .i_clear       (w_grant_any),
    .i_count       (w_count),
    .o_expired     (w_expired),
    .o_timeout_err (w_timeout_err)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state         <= IDLE;
      r_last_grant    <= GRANT_DATA;
      r_i_done        <= 1'b0;
      r_d_done        <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_i_readdata    <= '0;
      r_d_readdata    <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_mem_address <= bus.i_address[ADDR_W+1:2];
            r_mem_read    <= 1'b1;
            r_mem_write   <= 1'b0;
            r_last_grant  <= GRANT_INST;
            r_state       <= SERVE_I;
          end else if (w_d_elig) begin
            r_mem_address   <= bus.d_address[ADDR_W+1:2];
            r_mem_writedata <= bus.d_writedata;
            r_mem_read      <= bus.d_read;
            r_mem_write     <= bus.d_write;
            r_last_grant    <= GRANT_DATA;
            r_state         <= SERVE_D;
          end
        end
        SERVE_I: begin
          if (!bus.mem_busywait || w_expired) begin
            if (!bus.mem_busywait) begin
              r_i_readdata <= bus.mem_readdata;
            end
            r_i_done    <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= IDLE;
          end
        end
        SERVE_D: begin
          if (!bus.mem_busywait || w_expired) begin
            if (!bus.mem_busywait && r_mem_read) begin
              r_d_readdata <= bus.mem_readdata;
            end
            r_d_done    <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.i_busywait    = bus.i_read & ~r_i_done;
  assign bus.d_busywait    = (bus.d_read | bus.d_write) & ~r_d_done;
  assign bus.i_readdata    = r_i_readdata;
  assign bus.d_readdata    = r_d_readdata;
  assign bus.mem_read      = r_mem_read;
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_writedata = r_mem_writedata;
  assign bus.timeout_err   = w_timeout_err;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - randomized self-checking bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;
  import imem_dmem_arbiter_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int STUCK   = 1000;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  imem_dmem_arbiter_if #(.ADDR_W(8)) bus ();

  imem_dmem_arbiter #(
    .ADDR_W  (8),
    .TIMEOUT (TIMEOUT),
    .TO_W    (7)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Memory environment: busy for mem_lat cycles after a strobe appears.
  logic [31:0] mem_arr [256];
  int          mem_lat = 0;
  int          wait_cnt = 0;
  logic [7:0]  seen_addr = 8'h0;
  wire         strobe = bus.mem_read | bus.mem_write;

  assign bus.mem_busywait = strobe && (wait_cnt < mem_lat);
  assign bus.mem_readdata = mem_arr[bus.mem_address];

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0801_0010;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge CLK);
      if (strobe) wait_cnt <= wait_cnt + 1;
      else        wait_cnt <= 0;
      if (strobe && !bus.mem_busywait) begin
        seen_addr <= bus.mem_address;
        if (bus.mem_write) mem_arr[bus.mem_address] <= bus.mem_writedata;
      end
    end
  end

  // Reference model state.
  logic [31:0] shadow [256];
  logic [31:0] exp_i_rd;
  logic [31:0] exp_d_rd;
  logic        exp_err;
  logic        exp_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    check_eq("i_readdata", bus.i_readdata, exp_i_rd);
    check_eq("d_readdata", bus.d_readdata, exp_d_rd);
    check_eq("timeout_err", 32'(bus.timeout_err), 32'(exp_err));
  endtask

  task automatic model_data(input bit is_wr, input logic [7:0] idx, input logic [31:0] wd);
    if (is_wr) shadow[idx] = wd;
    else       exp_d_rd = shadow[idx];
  endtask

  task automatic single(input bit is_inst, input bit is_wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat);
    int         edges;
    logic [7:0] idx;
    bit         to;
    logic       busy;
    idx = addr[9:2];
    to  = (lat >= TIMEOUT);
    mem_lat = lat;
    @(posedge CLK);
    @(negedge CLK);
    if (is_inst) begin
      bus.i_read = 1'b1; bus.i_address = addr;
    end else begin
      bus.d_read = !is_wr; bus.d_write = is_wr; bus.d_address = addr; bus.d_writedata = wd;
    end
    #1;
    busy = is_inst ? bus.i_busywait : bus.d_busywait;
    check_eq("stall_same_cycle", 32'(busy), 32'd1);
    edges = 0;
    do begin
      @(posedge CLK); #1; edges++;
      busy = is_inst ? bus.i_busywait : bus.d_busywait;
    end while (busy && edges < 200);
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    check_eq("latency", 32'(edges), to ? 32'(TIMEOUT + 1) : 32'(lat + 2));
    if (to) begin
      exp_err = 1'b1;
      check_eq("strobes_dropped", 32'(strobe), 32'd0);
    end else begin
      check_eq("mem_address", 32'(seen_addr), 32'(idx));
      if (is_inst) exp_i_rd = shadow[idx];
      else         model_data(is_wr, idx, wd);
    end
    exp_last = is_inst ? GRANT_INST : GRANT_DATA;
    check_regs();
  endtask

  task automatic both(input logic [31:0] ia, input logic [31:0] da, input bit d_wr,
                      input logic [31:0] wd, input int lat);
    int ei, ed, n;
    bit i_first;
    i_first = (exp_last == GRANT_DATA);
    mem_lat = lat;
    @(posedge CLK);
    @(negedge CLK);
    bus.i_read = 1'b1; bus.i_address = ia;
    bus.d_read = !d_wr; bus.d_write = d_wr; bus.d_address = da; bus.d_writedata = wd;
    #1;
    check_eq("both_stall", {30'd0, bus.i_busywait, bus.d_busywait}, 32'd3);
    ei = 0; ed = 0; n = 0;
    while ((ei == 0 || ed == 0) && n < 400) begin
      @(posedge CLK); #1; n++;
      if (ei == 0 && !bus.i_busywait) begin ei = n; bus.i_read = 1'b0; end
      if (ed == 0 && !bus.d_busywait) begin ed = n; bus.d_read = 1'b0; bus.d_write = 1'b0; end
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    check_eq("inst_done_edge", 32'(ei), i_first ? 32'(lat + 2) : 32'(2 * lat + 4));
    check_eq("data_done_edge", 32'(ed), i_first ? 32'(2 * lat + 4) : 32'(lat + 2));
    if (i_first) begin
      exp_i_rd = shadow[ia[9:2]];
      model_data(d_wr, da[9:2], wd);
    end else begin
      model_data(d_wr, da[9:2], wd);
      exp_i_rd = shadow[ia[9:2]];
    end
    exp_last = i_first ? GRANT_DATA : GRANT_INST;
    check_regs();
  endtask

  task automatic model_reset();
    exp_i_rd = '0;
    exp_d_rd = '0;
    exp_err  = 1'b0;
    exp_last = GRANT_DATA;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
    model_reset();

    #12;
    check_eq("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check_eq("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check_eq("rst_busywait", {30'd0, bus.i_busywait, bus.d_busywait}, 32'd0);
    check_regs();
    @(negedge CLK);
    RESET = 1'b0;

    single(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);
    check_eq("fetch_0x10", bus.i_readdata, 32'h0801_0010);
    single(1'b0, 1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 3);
    single(1'b0, 1'b0, 32'h0000_0018, 32'h0, 3);
    check_eq("read_back_0x18", bus.d_readdata, 32'hDEAD_BEEF);
    single(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1);

    for (int k = 0; k < 4; k++) begin
      both($urandom(), $urandom(), k[0], $urandom(), k % 3);
    end

    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      case (kind)
        0:       single(1'b1, 1'b0, $urandom(), 32'h0, $urandom_range(0, 4));
        1:       single(1'b0, 1'(($urandom() & 1)), $urandom(), $urandom(), $urandom_range(0, 4));
        default: both($urandom(), $urandom(), 1'(($urandom() & 1)), $urandom(), $urandom_range(0, 4));
      endcase
    end

    single(1'b1, 1'b0, $urandom(), 32'h0, STUCK);
    single(1'b0, 1'b0, $urandom(), 32'h0, 2);
    single(1'b1, 1'b0, $urandom(), 32'h0, 0);

    mem_lat = STUCK;
    @(posedge CLK);
    @(negedge CLK);
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0040;
    repeat (5) @(posedge CLK);
    #2;
    RESET = 1'b1;
    bus.i_read = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check_eq("midrst_mem_address", 32'(bus.mem_address), 32'd0);
    check_eq("midrst_writedata", bus.mem_writedata, 32'd0);
    check_regs();
    #3;
    RESET = 1'b0;

    both(32'h0000_0010, 32'h0000_0018, 1'b0, 32'h0, 1);
    both($urandom(), $urandom(), 1'b1, $urandom(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
